// File: rtl/entropy_conditioner_if.sv
// Byte-stream and raw-bit signals between the entropy conditioner and its
// neighbours; the conditioner itself connects through the slave modport.
interface entropy_conditioner_if;
    logic       bitIn;
    logic       bitValid;
    logic       byteReady;
    logic [7:0] byteOut;
    logic       byteValid;
    logic       healthFail;
    logic       overflow;

    modport master (
        output bitIn, bitValid, byteReady,
        input  byteOut, byteValid, healthFail, overflow
    );

    modport slave (
        input  bitIn, bitValid, byteReady,
        output byteOut, byteValid, healthFail, overflow
    );
endinterface

// File: rtl/entropy_conditioner.sv
// Von Neumann debiaser with repetition-count health test, LSB-first byte
// packer and a small output FIFO.
module entropy_conditioner #(
    parameter int REP_CUTOFF = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clkIn,
    input  logic                 rstIn,
    entropy_conditioner_if.slave ec
);
    localparam int         AW      = $clog2(FIFO_DEPTH);
    localparam logic [7:0] CUTOFF  = 8'(REP_CUTOFF);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic        phase_q, phase_d;
    logic        first_q, first_d;
    logic [7:0]  pack_q, pack_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  run_q, run_d;
    logic        last_q, last_d;
    logic        health_q, health_d;
    logic        ovf_q, ovf_d;
    logic [AW:0] wr_q, wr_d;
    logic [AW:0] rd_q, rd_d;
    logic [7:0]  mem_q [FIFO_DEPTH];

    logic       emit;
    logic       push_req;
    logic       push;
    logic       drop;
    logic       pop;
    logic       empty;
    logic       full;
    logic       fail_now;
    logic [7:0] push_byte;

    // Run length of identical raw bits; zero only before the first bit after reset.
    always_comb begin
        run_d  = run_q;
        last_d = last_q;
        if (ec.bitValid) begin
            last_d = ec.bitIn;
            if (run_q == 8'd0 || ec.bitIn != last_q) begin
                run_d = 8'd1;
            end else if (run_q < CUTOFF) begin
                run_d = run_q + 8'd1;
            end
        end
    end

    assign fail_now  = ec.bitValid & ~health_q & (run_d == CUTOFF);
    assign emit      = ec.bitValid & phase_q & (first_q ^ ec.bitIn) & ~health_q;
    assign push_byte = {first_q, pack_q[7:1]};
    assign push_req  = emit & (cnt_q == 3'd7);

    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);

    // Output handshake: a byte transfers on any edge where byteValid and
    // byteReady are both high; byteOut is the FIFO head and advances next cycle.
    assign pop  = ec.byteValid & ec.byteReady;
    assign push = push_req & ~fail_now & (~full | pop);
    assign drop = push_req & ~fail_now & full & ~pop;

    always_comb begin
        phase_d  = phase_q;
        first_d  = first_q;
        pack_d   = pack_q;
        cnt_d    = cnt_q;
        wr_d     = wr_q;
        rd_d     = rd_q;
        health_d = health_q | fail_now;
        ovf_d    = ovf_q | drop;
        if (fail_now || health_q) begin
            phase_d = 1'b0;
            pack_d  = 8'h00;
            cnt_d   = 3'd0;
        end else if (ec.bitValid) begin
            phase_d = ~phase_q;
            if (!phase_q) begin
                first_d = ec.bitIn;
            end
            if (emit) begin
                pack_d = push_byte;
                cnt_d  = cnt_q + 3'd1;
            end
        end
        if (fail_now) begin
            wr_d = '0;
            rd_d = '0;
        end else begin
            if (push) begin
                wr_d = wr_q + PTR_ONE;
            end
            if (pop) begin
                rd_d = rd_q + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            phase_q  <= 1'b0;
            first_q  <= 1'b0;
            pack_q   <= 8'h00;
            cnt_q    <= 3'd0;
            run_q    <= 8'd0;
            last_q   <= 1'b0;
            health_q <= 1'b0;
            ovf_q    <= 1'b0;
            wr_q     <= '0;
            rd_q     <= '0;
        end else begin
            phase_q  <= phase_d;
            first_q  <= first_d;
            pack_q   <= pack_d;
            cnt_q    <= cnt_d;
            run_q    <= run_d;
            last_q   <= last_d;
            health_q <= health_d;
            ovf_q    <= ovf_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
        end
    end

    // Storage is cleared on reset so byteOut reads 00 until the first push.
    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else if (push) begin
            mem_q[wr_q[AW-1:0]] <= push_byte;
        end
    end

    assign ec.byteOut    = mem_q[rd_q[AW-1:0]];
    assign ec.byteValid  = ~empty & ~health_q;
    assign ec.healthFail = health_q;
    assign ec.overflow   = ovf_q;
endmodule

// File: doc/entropy_conditioner.md
ENTROPY_CONDITIONER -- requirements
Module: entropy_conditioner

Interface
REQ-001 SHALL have parameter REP_CUTOFF, default 32: repetition-count-test cutoff, legal range 2..255.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: output FIFO entries, power of 2, at least 2.
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 SHALL have port clkIn  input  1  system clock; all state changes on its rising edge.
REQ-005 SHALL have port rstIn  input  1  synchronous active-high reset.
REQ-006 SHALL have port bitIn  input  1  raw entropy sample from the RO generator.
REQ-007 SHALL have port bitValid  input  1  single-cycle strobe: bitIn holds a fresh raw bit.
REQ-008 SHALL have port byteReady  input  1  consumer accepts byteOut this cycle.
REQ-009 SHALL have port byteOut  output  8  FIFO head byte.
REQ-010 SHALL have port byteValid  output  1  FIFO not empty.
REQ-011 SHALL have port healthFail  output  1  sticky repetition-count failure.
REQ-012 SHALL have port overflow  output  1  sticky flag: a conditioned byte was dropped.

Function
REQ-013 SHALL accept a raw bit only on a clkIn edge where bitValid=1 and rstIn=0.
REQ-014 SHALL group accepted raw bits into consecutive non-overlapping pairs (first, second), tracked by a pair-phase flag.
REQ-015 SHALL apply the Von Neumann rule on each completed pair:
- pair 10 -> emit 1
- pair 01 -> emit 0
- pairs 00 and 11 -> discard, emit nothing.
REQ-016 SHALL shift emitted bits into an 8-bit packer LSB-first: the first emitted bit becomes byteOut[0].
REQ-017 SHALL push the packed byte into the FIFO on the same edge that accepts the 8th emitted bit, and restart the packer count at 0.
REQ-018 SHALL make byteValid=1 on the cycle after the push edge (single registered latency).
REQ-019 SHALL implement the repetition count test on all accepted raw bits, including discarded pairs:
- the run counter is 1 on the first bit after reset;
- the counter increments on each identical consecutive bit, saturating at REP_CUTOFF;
- the counter resets to 1 on each bit change.
REQ-020 SHALL set healthFail on the edge where the run counter reaches REP_CUTOFF; healthFail SHALL stay set until reset.
REQ-021 SHALL, on the edge healthFail sets:
- flush the FIFO;
- clear the packer and pair phase;
- block all further pushes while healthFail=1;
- keep byteValid=0 while healthFail=1.
REQ-022 SHALL pop the FIFO on an edge where byteValid=1 and byteReady=1; byteOut SHALL present the next entry on the following cycle.
REQ-023 SHALL drop the new byte and set overflow (sticky until reset) when a push occurs with the FIFO full and no pop on that edge.
REQ-024 SHALL accept the push without setting overflow when a push and a pop occur on the same edge with the FIFO full.
REQ-025 SHALL handle a push and a pop on the same edge with the FIFO empty as pop-ignored, push-stored.
REQ-026 SHALL keep FIFO pointers (log2(FIFO_DEPTH)+1 bits) wrapping modulo 2*FIFO_DEPTH, with full/empty derived from the MSB comparison.

Reset
REQ-027 SHALL, on rstIn=1, clear all of the following to 0 on the next edge: byteValid, healthFail, overflow, FIFO pointers, packer, packer count, pair phase, run counter, last-bit register.
REQ-028 SHALL hold byteOut at 8'h00 after reset until the first push.
REQ-029 SHALL let reset override all simultaneous bitValid and byteReady activity.
REQ-030 SHALL discard a partially assembled pair or byte when reset is applied mid-operation.

Verification
REQ-031 SHALL pass: reset, byteReady=1, feed raw 1,0 x8 -> one byte 8'hFF; then 0,1 x8 -> 8'h00; then alternate pairs 10,01 x4 -> 8'h55.
REQ-032 SHALL pass: interleave a 00 or 11 pair between every useful pair of a 10 x8 stream -> exactly one byte 8'hFF, healthFail=0.
REQ-033 SHALL pass with REP_CUTOFF=32:
- 31 identical raw bits -> healthFail=0;
- 32nd identical bit -> healthFail=1 on that edge's output;
- byteValid=0 thereafter, even with further valid pairs.
REQ-034 SHALL pass with byteReady=0: push 5 bytes 8'h01..8'h05 -> overflow=1; then byteReady=1 -> drains 01,02,03,04 in order, then byteValid=0.
REQ-035 SHALL pass: with the FIFO full and byteReady=1 held, push a 5th byte on the pop edge -> overflow stays 0, the 5th byte is delivered last.
REQ-036 SHALL pass: after 5 emitted bits plus one half-pair, assert rstIn for 1 cycle, then feed 10 x8 -> exactly 8'hFF, all flags 0.
